// File: rtl/power_mon_pkg.sv
// power_mon_pkg: state encoding, error codes and the power-monitor register-write table
package power_mon_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DLY       = 4'd1;
    localparam logic [3:0] S_LOAD      = 4'd2;
    localparam logic [3:0] S_GO_HI     = 4'd3;
    localparam logic [3:0] S_WAIT_BUSY = 4'd4;
    localparam logic [3:0] S_WAIT_DONE = 4'd5;
    localparam logic [3:0] S_CHECK     = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    localparam logic [1:0] ERR_NACK     = 2'b01;
    localparam logic [1:0] ERR_TO_START = 2'b10;
    localparam logic [1:0] ERR_TO_DONE  = 2'b11;

    // {pointer, data16} for each table entry; unused slots read as zero
    function automatic logic [23:0] pm_cfg_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return {8'h00, 16'h4527};
            3'd1:    return {8'h05, 16'h0A00};
            3'd2:    return {8'h06, 16'h0000};
            3'd3:    return {8'h07, 16'h0000};
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/power_mon_cfg_seq.sv
// power_mon_cfg_seq: walks the config table through the I2C word-write engine with retries
module power_mon_cfg_seq
    import power_mon_pkg::*;
#(
    parameter int          NUM_ENTRIES = 4,
    parameter logic [7:0]  SLAVE_ADDR  = 8'h80,
    parameter int          GO_CYC      = 4,
    parameter int          TIMEOUT_CYC = 4095,
    parameter int          MAX_RETRY   = 2,
    parameter int          AUTO_START  = 1,
    parameter int          START_DLY   = 1000
) (
    input  logic        PT_CK,
    input  logic        RESET,
    input  logic        START,
    input  logic        END_OK,
    input  logic        ACK_OK,
    output logic        GO,
    output logic [7:0]  SLAVE_ADDRESS,
    output logic [7:0]  POINTER,
    output logic [15:0] WDATA16,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [2:0]  ERR_IDX,
    output logic [1:0]  ERR_CODE
);

    localparam int         CW    = 16;
    localparam logic [3:0] S_RST = (AUTO_START != 0) ? S_DLY : S_IDLE;

    logic [3:0]    state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx, retry;
    logic [1:0]    code;
    logic          ack_q, fail, give_up, expired, last, start_ok, acked;

    assign SLAVE_ADDRESS = SLAVE_ADDR;
    assign expired  = cnt == CW'(TIMEOUT_CYC);
    assign last     = idx == 3'(NUM_ENTRIES - 1);
    assign start_ok = START && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign acked    = state == S_CHECK && ack_q;
    assign give_up  = fail && retry >= 3'(MAX_RETRY);

    // next-state and failure decode; any failure either retries the entry or parks in ERR_S
    always_comb begin
        nxt  = state;
        fail = 1'b0;
        code = ERR_NACK;
        case (state)
            S_IDLE, S_DONE, S_ERR: nxt = START ? S_LOAD : state;
            S_DLY:   nxt = (cnt == CW'(START_DLY - 1)) ? S_LOAD : S_DLY;
            S_LOAD:  nxt = END_OK ? S_GO_HI : S_LOAD;
            S_GO_HI: nxt = (cnt == CW'(GO_CYC - 1)) ? S_WAIT_BUSY : S_GO_HI;
            S_WAIT_BUSY: begin
                nxt  = END_OK ? S_WAIT_BUSY : S_WAIT_DONE;
                fail = END_OK && expired;
                code = ERR_TO_START;
            end
            S_WAIT_DONE: begin
                nxt  = END_OK ? S_CHECK : S_WAIT_DONE;
                fail = !END_OK && expired;
                code = ERR_TO_DONE;
            end
            S_CHECK: begin
                nxt  = last ? S_DONE : S_LOAD;
                fail = !ack_q;
            end
            default: nxt = S_IDLE;
        endcase
        if (fail) nxt = give_up ? S_ERR : S_LOAD;
    end

    // state register and per-state cycle counter (cleared on every state entry, saturating)
    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
        end
    end

    // registered handshake outputs so GO/BUSY never glitch on state decode
    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            GO   <= 1'b0;
            BUSY <= 1'b0;
        end else begin
            GO   <= nxt == S_GO_HI;
            BUSY <= !(nxt == S_IDLE || nxt == S_DONE || nxt == S_ERR);
        end
    end

    // table fetch in LOAD holds POINTER/WDATA16 through the whole transfer; ack sampled while engine busy
    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            POINTER <= '0;
            WDATA16 <= '0;
            ack_q   <= 1'b0;
        end else begin
            if (state == S_LOAD) {POINTER, WDATA16} <= pm_cfg_entry(idx);
            if (state == S_LOAD) ack_q <= 1'b0;
            else if (state == S_WAIT_DONE && !END_OK) ack_q <= ACK_OK;
        end
    end

    // entry index and retry bookkeeping
    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            idx   <= '0;
            retry <= '0;
        end else if (start_ok) begin
            idx   <= '0;
            retry <= '0;
        end else if (acked) begin
            idx   <= last ? idx : idx + 3'd1;
            retry <= '0;
        end else if (fail && !give_up) begin
            retry <= retry + 3'd1;
        end
    end

    // sticky completion / error status, cleared only by a new START
    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_IDX  <= '0;
            ERR_CODE <= '0;
        end else if (start_ok) begin
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_IDX  <= '0;
            ERR_CODE <= '0;
        end else if (acked && last) begin
            DONE <= 1'b1;
        end else if (give_up) begin
            ERR      <= 1'b1;
            ERR_IDX  <= idx;
            ERR_CODE <= code;
        end
    end

endmodule

// File: tb/tb_power_mon_cfg_seq.sv
// tb_power_mon_cfg_seq: scoreboard bench with a behavioural write-engine model
module tb_power_mon_cfg_seq;

    localparam int GO_CYC    = 4;
    localparam int MAX_RETRY = 2;
    localparam int START_DLY = 10;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [2:0] idx;
        logic [1:0] code;
    } out_t;

    logic        pt_ck = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        end_ok, ack_ok;
    logic        go, busy, done, err;
    logic [7:0]  slave_address, pointer;
    logic [15:0] wdata16;
    logic [2:0]  err_idx;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int outs_seen = 0;
    int go_rises = 0;

    logic [23:0] exp_x[$];
    out_t        exp_o[$];
    logic [23:0] tbl [4] = '{24'h004527, 24'h050A00, 24'h060000, 24'h070000};

    int         test_id = 0;
    int         mode = 0;
    int         nack_n = 0;
    logic [7:0] nack_ptr = 8'hFF;
    logic       hold_low = 1'b0;
    logic       eng_end = 1'b1;
    logic       eng_ack = 1'b0;

    assign end_ok = eng_end && !hold_low;
    assign ack_ok = eng_ack && !hold_low;

    always #5 pt_ck = ~pt_ck;

    power_mon_cfg_seq #(
        .NUM_ENTRIES(4), .SLAVE_ADDR(8'h80), .GO_CYC(GO_CYC), .TIMEOUT_CYC(4095),
        .MAX_RETRY(MAX_RETRY), .AUTO_START(1), .START_DLY(START_DLY)
    ) dut (
        .PT_CK(pt_ck), .RESET(reset), .START(start), .END_OK(end_ok), .ACK_OK(ack_ok),
        .GO(go), .SLAVE_ADDRESS(slave_address), .POINTER(pointer), .WDATA16(wdata16),
        .BUSY(busy), .DONE(done), .ERR(err), .ERR_IDX(err_idx), .ERR_CODE(err_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // reference model: every entry gets up to MAX_RETRY+1 attempts, each attempt is one transfer
    function automatic void expect_run(input logic [7:0] np, input int nn, input bit never);
        out_t o;
        bit   ok;
        for (int i = 0; i < 4; i++) begin
            ok = 1'b0;
            for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
                exp_x.push_back(tbl[i]);
                ok = !never && !(tbl[i][23:16] == np && a < nn);
            end
            if (!ok) begin
                o.done = 1'b0; o.err = 1'b1; o.idx = 3'(i); o.code = never ? 2'b10 : 2'b01;
                exp_o.push_back(o);
                return;
            end
        end
        o.done = 1'b1; o.err = 1'b0; o.idx = 3'd0; o.code = 2'b00;
        exp_o.push_back(o);
    endfunction

    // engine model: END_OK drops 2 cycles after GO falls, stays low 40 cycles
    initial begin
        int   eng_id = 0, dly = 0, low = 0;
        int   attempts [256];
        logic e_go = 1'b0, e_ack = 1'b0;
        forever begin
            @(negedge pt_ck);
            if (eng_id != test_id) begin
                eng_id = test_id;
                foreach (attempts[i]) attempts[i] = 0;
            end
            if (go && !e_go) begin
                e_ack = !(pointer == nack_ptr && attempts[pointer] < nack_n);
                attempts[pointer]++;
            end
            if (!go && e_go && mode == 0) dly = 2;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) begin eng_end = 1'b0; eng_ack = e_ack; low = 40; end
            end else if (low > 0) begin
                low--;
                if (low == 0) begin eng_end = 1'b1; eng_ack = 1'b0; end
            end
            e_go = go;
        end
    end

    // monitor: pops the scoreboard on every finished GO pulse and every DONE/ERR rise
    initial begin
        logic        gp = 1'b0, fp = 1'b0;
        logic [23:0] cap = '0, e;
        out_t        eo;
        int          glen = 0;
        forever begin
            @(negedge pt_ck);
            if (reset) begin
                gp = 1'b0;
                fp = 1'b0;
            end else begin
                if (go && !gp) begin
                    cap = {pointer, wdata16};
                    glen = 1;
                    go_rises++;
                end else if (go) glen++;
                else if (gp) begin
                    chk("go_len", glen, GO_CYC);
                    chk("ptr_hold", {pointer, wdata16}, cap);
                    if (exp_x.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer_extra at %0t: actual=%0h required=none", $time, cap);
                    end else begin
                        e = exp_x.pop_front();
                        chk("xfer", cap, e);
                    end
                    xfers++;
                end
                if ((done || err) && !fp) begin
                    if (exp_o.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL outcome_extra at %0t: actual=%0h required=none", $time,
                                 {done, err, err_idx, err_code});
                    end else begin
                        eo = exp_o.pop_front();
                        chk("outcome", {done, err, err_idx, err_code}, eo);
                    end
                    chk("busy_end", busy, 0);
                    outs_seen++;
                end
                gp = go;
                fp = done || err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pt_ck);
    endtask

    task automatic do_reset();
        @(negedge pt_ck);
        reset = 1'b1;
        #1;
        chk("rst_go", go, 0);
        chk("rst_flags", {done, err}, 0);
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_data", {pointer, wdata16}, 0);
        chk("rst_addr", slave_address, 8'h80);
        chk("rst_err", {err_idx, err_code}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_out(input string name, input int base, input int budget);
        int c = 0;
        while (outs_seen <= base && c < budget) begin
            cyc(1);
            c++;
        end
        chk(name, outs_seen > base, 1);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int c = 0;
        while (xfers < target && c < budget) begin
            cyc(1);
            c++;
        end
        chk(name, xfers >= target, 1);
    endtask

    task automatic setup(input logic [7:0] np, input int nn, input int md);
        test_id++;
        nack_ptr = np;
        nack_n = nn;
        mode = md;
        exp_x.delete();
        exp_o.delete();
        expect_run(np, nn, md == 1);
    endtask

    initial begin
        int b, g, c;
        // 1: auto-start, all acked; START while busy is ignored
        setup(8'hFF, 0, 0);
        do_reset();
        b = outs_seen;
        cyc(3);
        chk("t1_dly_busy", busy, 1);
        chk("t1_dly_go", go, 0);
        wait_xfers("t1_first_xfer", xfers + 1, 300);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_out("t1_end", b, 2000);
        chk("t1_q", exp_x.size(), 0);
        chk("t1_state", {done, err, busy}, 3'b100);
        // 2: entry 1 NACKs twice then acks
        setup(8'h05, 2, 0);
        do_reset();
        b = outs_seen;
        wait_out("t2_end", b, 3000);
        chk("t2_q", exp_x.size(), 0);
        chk("t2_state", {done, err}, 2'b10);
        // 3: entry 2 always NACKs
        setup(8'h06, 255, 0);
        do_reset();
        b = outs_seen;
        wait_out("t3_end", b, 3000);
        chk("t3_q", exp_x.size(), 0);
        g = go_rises;
        cyc(100);
        chk("t3_go_quiet", go_rises - g, 0);
        chk("t3_err", {done, err, err_idx, err_code}, {1'b0, 1'b1, 3'd2, 2'b01});
        // 4: engine never starts a frame
        setup(8'hFF, 0, 1);
        do_reset();
        b = outs_seen;
        wait_out("t4_end", b, 20000);
        chk("t4_q", exp_x.size(), 0);
        chk("t4_err", {done, err, err_idx, err_code}, {1'b0, 1'b1, 3'd0, 2'b10});
        // 5: END_OK held low across start-up blocks the first GO
        setup(8'hFF, 0, 0);
        hold_low = 1'b1;
        do_reset();
        b = outs_seen;
        g = go_rises;
        cyc(40);
        chk("t5_no_go", go_rises - g, 0);
        chk("t5_busy", busy, 1);
        hold_low = 1'b0;
        wait_out("t5_end", b, 2000);
        chk("t5_q", exp_x.size(), 0);
        // 6: reset during WAIT_DONE of entry 2, then auto rerun and a START rerun
        setup(8'hFF, 0, 0);
        do_reset();
        wait_xfers("t6_three_xfers", xfers + 3, 500);
        c = 0;
        while (end_ok && c < 20) begin
            cyc(1);
            c++;
        end
        chk("t6_engine_busy", end_ok, 0);
        cyc(5);
        reset = 1'b1;
        #1;
        chk("t6_async", {go, done, err, busy}, 4'b0000);
        exp_x.delete();
        exp_o.delete();
        expect_run(8'hFF, 0, 1'b0);
        cyc(2);
        reset = 1'b0;
        b = outs_seen;
        wait_out("t6_rerun", b, 2000);
        chk("t6_q", exp_x.size(), 0);
        expect_run(8'hFF, 0, 1'b0);
        b = outs_seen;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t6_restart", {busy, done}, 2'b10);
        wait_out("t6_start_run", b, 2000);
        chk("t6_q2", exp_x.size(), 0);
        chk("t6_state", {done, err}, 2'b10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
